buffer_enteros_ctrl: RTL and testbench

Sequencer for the 16x16 integer-pixel recirculating row buffer in the FME datapath. Loads WIDTH_FIL rows from an upstream source through a valid/ready handshake, then recirculates the buffer NUM_PASSES times so downstream interpolation and SAD stages see the full block once per fractional search position. Drives the buffer's wr/en pins directly, tags each output row with its row and pass index, and signals completion.

---
 rtl/buffer_enteros_ctrl_if.sv | 25 ++
 rtl/buffer_enteros_ctrl.sv | 150 +++++++++++++++
 tb/tb_buffer_enteros_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_enteros_ctrl_if.sv
// Handshake and buffer-control bundle for buffer_enteros_ctrl.
// master: the controller side. slave: the upstream/downstream/buffer side.
interface buffer_enteros_ctrl_if #(
  parameter int ROW_W  = 4,
  parameter int PASS_W = 4
);
  logic              src_valid;
  logic              src_ready;
  logic              out_ready;
  logic              out_valid;
  logic              buf_wr;
  logic              buf_en;
  logic [ROW_W-1:0]  row_idx;
  logic [PASS_W-1:0] pass_idx;

  modport master (
    input  src_valid, out_ready,
    output src_ready, out_valid, buf_wr, buf_en, row_idx, pass_idx
  );

  modport slave (
    output src_valid, out_ready,
    input  src_ready, out_valid, buf_wr, buf_en, row_idx, pass_idx
  );
endinterface

// File: rtl/buffer_enteros_ctrl.sv
// Sequencer for the integer-pixel recirculating row buffer: loads WIDTH_FIL
// rows, then rotates the buffer NUM_PASSES times, tagging each row presented
// with its row and pass index.
// Optional macro BUFFER_CTRL_STALL_CNT_EN adds a saturating 16-bit count of
// downstream stall cycles (stall_cnt).
//
// state | meaning
// IDLE  | waiting for start, buffer untouched
// LOAD  | shifting upstream rows into the buffer (buf_wr=0)
// READ  | presenting rows downstream and recirculating them (buf_wr=1)
// DONE  | one-cycle completion pulse, then IDLE
module buffer_enteros_ctrl #(
  parameter int WIDTH_FIL  = 16,
  parameter int NUM_PASSES = 9,
  parameter int ROW_W      = 4,
  parameter int PASS_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
`ifdef BUFFER_CTRL_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  buffer_enteros_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(WIDTH_FIL - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              done_q;
  logic              src_ready_c, out_valid_c, buf_wr_c, buf_en_c, busy_c;

  // State, indices and the registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pass_q  <= pass_d;
      done_q  <= (state_d == DONE);
    end
  end

  // Next-state, index update and buffer/handshake decode.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    pass_d      = pass_q;
    src_ready_c = 1'b0;
    out_valid_c = 1'b0;
    buf_wr_c    = 1'b1;
    buf_en_c    = 1'b0;
    busy_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          row_d   = '0;
          pass_d  = '0;
        end
      end
      LOAD: begin
        src_ready_c = 1'b1;
        buf_wr_c    = 1'b0;
        buf_en_c    = bus.src_valid;
        busy_c      = 1'b1;
        if (bus.src_valid) begin
          if (row_q == ROW_LAST) begin
            state_d = READ;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      READ: begin
        out_valid_c = 1'b1;
        buf_en_c    = bus.out_ready;
        busy_c      = 1'b1;
        if (bus.out_ready) begin
          if (row_q == ROW_LAST) begin
            row_d = '0;
            // Hold pass_idx at its last value so it never exceeds NUM_PASSES-1.
            if (pass_q == PASS_LAST) state_d = DONE;
            else                     pass_d  = pass_q + PASS_W'(1);
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        pass_d  = '0;
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
        pass_d  = '0;
      end
    endcase

    // Abort overrides everything, including a simultaneous start or last handshake.
    if (abort) begin
      state_d  = IDLE;
      row_d    = '0;
      pass_d   = '0;
      buf_en_c = 1'b0;
    end
  end

`ifdef BUFFER_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of READ cycles stalled by downstream; cleared per block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (state_q == IDLE && state_d == LOAD)
      stall_q <= '0;
    else if (state_q == READ && !bus.out_ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

  assign bus.src_ready = src_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.buf_wr    = buf_wr_c;
  assign bus.buf_en    = buf_en_c;
  assign bus.row_idx   = row_q;
  assign bus.pass_idx  = pass_q;
  assign busy          = busy_c;
  assign done          = done_q;

endmodule

// File: tb/tb_buffer_enteros_ctrl.sv
// Bench for buffer_enteros_ctrl: a default-size instance driving a behavioural
// row buffer with a scoreboard, plus a 4-row single-pass instance.
module tb_buffer_enteros_ctrl;

  localparam int W = 16;
  localparam int P = 9;

  typedef struct packed {
    logic [3:0]  p;
    logic [3:0]  r;
    logic [15:0] d;
  } exp_t;

  logic clk;
  logic rst;
  logic start, abort, busy, done;
  logic start_b, abort_b, busy_b, done_b;
  logic [15:0] fila_in;
  logic [15:0] bufm [W];
  logic [15:0] ld_rows [W];
  logic [4:0]  pat;
  logic        burst_on;
  int          bk;
  int          total, bad;
  int          ld_cnt, done_cnt;
  bit          expect_read;
  exp_t        q[$];
`ifdef BUFFER_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] stall_cnt_b;
`endif

  buffer_enteros_ctrl_if #(.ROW_W(4), .PASS_W(4)) aif();
  buffer_enteros_ctrl_if #(.ROW_W(2), .PASS_W(1)) bif();

  buffer_enteros_ctrl #(.WIDTH_FIL(W), .NUM_PASSES(P), .ROW_W(4), .PASS_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
`ifdef BUFFER_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .bus(aif)
  );

  buffer_enteros_ctrl #(.WIDTH_FIL(4), .NUM_PASSES(1), .ROW_W(2), .PASS_W(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
`ifdef BUFFER_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt_b),
`endif
    .bus(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural row buffer: shift in on load, rotate on recirculate; output is entry 0.
  always @(posedge clk) begin
    if (aif.buf_en) begin
      for (int i = 0; i < W - 1; i++) bufm[i] <= bufm[i+1];
      bufm[W-1] <= aif.buf_wr ? bufm[0] : fila_in;
    end
  end

  // New candidate row data every cycle, stable around the sampling edge.
  always @(posedge clk) begin
    #1;
    fila_in = 16'($urandom);
    if (burst_on) begin
      aif.src_valid = pat[bk];
      bk = (bk + 1) % 5;
    end
  end

  // Scoreboard: loaded rows push the expected read stream; reads pop and compare.
  always @(negedge clk) begin
    if (rst || abort) begin
      q.delete();
      ld_cnt = 0;
      expect_read = 1'b0;
    end else begin
      if (expect_read) begin
        check_val("ld_to_rd", {30'd0, aif.out_valid, aif.src_ready}, 32'd2);
        expect_read = 1'b0;
      end
      if (aif.src_ready) begin
        check_val("ld_en", aif.buf_en, aif.src_valid);
        check_val("ld_wr", aif.buf_wr, 0);
        if (aif.src_valid) begin
          check_val("ld_row", aif.row_idx, ld_cnt);
          ld_rows[ld_cnt] = fila_in;
          ld_cnt++;
          if (ld_cnt == W) begin
            for (int p = 0; p < P; p++)
              for (int r = 0; r < W; r++) begin
                exp_t e;
                e.p = 4'(p);
                e.r = 4'(r);
                e.d = ld_rows[r];
                q.push_back(e);
              end
            ld_cnt = 0;
            expect_read = 1'b1;
          end
        end
      end
      if (aif.out_valid) begin
        check_val("rd_en", aif.buf_en, aif.out_ready);
        check_val("rd_wr", aif.buf_wr, 1);
        if (aif.out_ready) begin
          if (q.size() == 0) begin
            check_val("rd_extra", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check_val("rd_data", bufm[0], e.d);
            check_val("rd_row", aif.row_idx, e.r);
            check_val("rd_pass", aif.pass_idx, e.p);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic wait_done(input int maxc, output int cyc);
    int n;
    n = 0;
    cyc = -1;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (done) begin
        cyc = n;
        return;
      end
    end
    check_val("timeout_done", 0, 1);
  endtask

  task automatic wait_pos(input int p, input int r);
    int n;
    n = 0;
    while (!(aif.out_valid && aif.pass_idx == 4'(p) && aif.row_idx == 4'(r)) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) check_val("timeout_pos", 0, 1);
  endtask

  // Called right after a posedge+1: pulses start for one edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_block(input string tag, input int exp_cyc);
    int cyc, d0;
    d0 = done_cnt;
    wait_done(exp_cyc + 50, cyc);
    check_val({tag, "_cycles"}, cyc, exp_cyc);
    @(negedge clk);
    check_val({tag, "_done_1cyc"}, done, 0);
    check_val({tag, "_idle"}, busy, 0);
    check_val({tag, "_rows_left"}, q.size(), 0);
    check_val({tag, "_done_cnt"}, done_cnt - d0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int d0;
    logic [15:0] held;
    total = 0; bad = 0; ld_cnt = 0; done_cnt = 0; expect_read = 1'b0;
    pat = 5'b01101;
    bk = 0;
    burst_on = 1'b0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    aif.src_valid = 1'b0; aif.out_ready = 1'b0;
    bif.src_valid = 1'b1; bif.out_ready = 1'b1;
    fila_in = '0;

    // Reset state.
    @(negedge clk);
    check_val("rst_src_ready", aif.src_ready, 0);
    check_val("rst_out_valid", aif.out_valid, 0);
    check_val("rst_buf_en", aif.buf_en, 0);
    check_val("rst_buf_wr", aif.buf_wr, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_row", aif.row_idx, 0);
    check_val("rst_pass", aif.pass_idx, 0);
    check_val("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal block, always-valid source and always-ready sink.
    aif.src_valid = 1'b1;
    aif.out_ready = 1'b1;
    pulse_start();
    finish_block("nominal", W + W * P + 1);

    // Bursty source.
    burst_on = 1'b1;
    bk = 0;
    pulse_start();
    wait_pos(0, 0);
    burst_on = 1'b0;
    aif.src_valid = 1'b1;
    d0 = done_cnt;
    begin
      int cyc;
      wait_done(W * P + 50, cyc);
      check_val("burst_rd_cycles", cyc, W * P + 1);
    end
    @(negedge clk);
    check_val("burst_done_cnt", done_cnt - d0, 1);
    check_val("burst_rows_left", q.size(), 0);
    @(posedge clk);
    #1;

    // Downstream stall at pass 2, row 7.
    pulse_start();
`ifdef BUFFER_CTRL_STALL_CNT_EN
    check_val("stall_clr", stall_cnt, 0);
`endif
    wait_pos(2, 7);
    aif.out_ready = 1'b0;
    held = bufm[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_row", aif.row_idx, 7);
      check_val("stall_pass", aif.pass_idx, 2);
      check_val("stall_valid", aif.out_valid, 1);
      check_val("stall_data", bufm[0], held);
      @(posedge clk);
    end
    #1;
`ifdef BUFFER_CTRL_STALL_CNT_EN
    check_val("stall_cnt", stall_cnt, 5);
`endif
    aif.out_ready = 1'b1;
    begin
      int cyc;
      wait_done(W * P, cyc);
      if (cyc < 0) check_val("stall_no_done", 0, 1);
    end
    @(negedge clk);
    check_val("stall_rows_left", q.size(), 0);
    @(posedge clk);
    #1;

    // Abort during READ pass 4, row 10, then a clean reload.
    pulse_start();
    wait_pos(4, 10);
    d0 = done_cnt;
    abort = 1'b1;
    #1;
    check_val("abort_buf_en", aif.buf_en, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_row", aif.row_idx, 0);
    check_val("abort_pass", aif.pass_idx, 0);
    check_val("abort_valid", aif.out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_no_done", done_cnt - d0, 0);
    pulse_start();
    finish_block("reload", W + W * P + 1);

    // Abort and start together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_val("abort_start_idle", busy, 0);

    // Reset mid-READ (pass 3).
    pulse_start();
    wait_pos(3, 5);
    rst = 1'b1;
    #1;
    check_val("mrst_src_ready", aif.src_ready, 0);
    check_val("mrst_out_valid", aif.out_valid, 0);
    check_val("mrst_buf_en", aif.buf_en, 0);
    check_val("mrst_buf_wr", aif.buf_wr, 1);
    check_val("mrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("mrst_row", aif.row_idx, 0);
    check_val("mrst_pass", aif.pass_idx, 0);
    pulse_start();
    finish_block("after_rst", W + W * P + 1);

    // Small instance: 4 rows, 1 pass; a start while busy is ignored.
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check_val("b_row", bif.row_idx, (c - 1) % 4);
      check_val("b_pass", bif.pass_idx, 0);
      check_val("b_busy", busy_b, 1);
      check_val("b_early_done", done_b, 0);
      check_val("b_phase", {31'd0, bif.out_valid}, (c > 4) ? 1 : 0);
      if (c == 3) start_b = 1'b1;
      if (c == 4) start_b = 1'b0;
    end
    @(negedge clk);
    check_val("b_done_c9", done_b, 1);
    @(negedge clk);
    check_val("b_done_off", done_b, 0);
    check_val("b_idle", busy_b, 0);
    repeat (3) @(negedge clk);
    check_val("b_no_restart", busy_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
